// File: rtl/qspi_seq_pkg.sv
// -----------------------------------------------------------------------------
// qspi_seq_pkg
// Shared definitions for the QSPI flash command sequencer:
//   - N25Q-class flash opcodes issued to qspi_master
//   - host operation encoding (op_e)
//   - sequencer FSM state encoding (state_e)
// -----------------------------------------------------------------------------
package qspi_seq_pkg;

    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_PP   = 8'h02;
    localparam logic [7:0] CMD_SE   = 8'hD8;
    localparam logic [7:0] CMD_RDSR = 8'h05;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_PROGRAM = 2'b01,
        OP_ERASE   = 2'b10,
        OP_RSVD    = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WREN_ISS,
        ST_WREN_WAIT,
        ST_OP_ISS,
        ST_OP_WAIT,
        ST_GAP,
        ST_POLL_ISS,
        ST_POLL_WAIT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/qspi_flash_seq.sv
// -----------------------------------------------------------------------------
// qspi_flash_seq
// Turns single host requests (READ / PROGRAM / ERASE) into the flash command
// sequence for qspi_master. PROGRAM and ERASE run WREN, the operation, then
// RDSR polling (separated by POLL_GAP idle clocks) until WIP=0.
//
// Optional feature: define QSPI_SEQ_POLL_TIMEOUT_EN to bound polling to
// POLL_MAX RDSR transactions; exceeding it completes with o_rsp_err=1.
//
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_req_valid/o_req_ready        host request handshake (ready only in IDLE)
//   i_req_op/addr/data             operation, flash address, program data
//   o_rsp_valid/data/err           one-cycle completion, read data, error flag
//   o_m_enable                     one-cycle start pulse to the master
//   o_m_command/addr/data/rw       master transaction fields (held until done)
//   o_m_burst_enable               tied 0
//   i_m_busy/i_m_done              master status
//   i_m_read_word                  master read result
// -----------------------------------------------------------------------------
module qspi_flash_seq
    import qspi_seq_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 24,
    parameter int POLL_GAP = 16,
    parameter int POLL_MAX = 4096
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [1:0]        i_req_op,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_data,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_err,
    output logic              o_m_enable,
    output logic [7:0]        o_m_command,
    output logic [ADDR_W-1:0] o_m_addr,
    output logic [DATA_W-1:0] o_m_data,
    output logic              o_m_rw,
    output logic              o_m_burst_enable,
    input  logic              i_m_busy,
    input  logic              i_m_done,
    input  logic [DATA_W-1:0] i_m_read_word
);

    // A zero-width counter is not legal, so POLL_GAP=0 still gets one bit.
    localparam int GAP_W = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

    state_e              state_q,     state_d;
    op_e                 op_q,        op_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [DATA_W-1:0]   data_q,      data_d;
    logic [GAP_W-1:0]    gap_q,       gap_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q,  rsp_data_d;
    logic                rsp_err_q,   rsp_err_d;
    logic                m_enable_q,  m_enable_d;
    logic [7:0]          m_command_q, m_command_d;
    logic [ADDR_W-1:0]   m_addr_q,    m_addr_d;
    logic [DATA_W-1:0]   m_data_q,    m_data_d;
    logic                m_rw_q,      m_rw_d;

`ifdef QSPI_SEQ_POLL_TIMEOUT_EN
    localparam int POLL_W = $clog2(POLL_MAX + 1);
    logic [POLL_W-1:0]   poll_q,      poll_d;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_READ;
            addr_q      <= '0;
            data_q      <= '0;
            gap_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            m_enable_q  <= 1'b0;
            m_command_q <= '0;
            m_addr_q    <= '0;
            m_data_q    <= '0;
            m_rw_q      <= 1'b0;
`ifdef QSPI_SEQ_POLL_TIMEOUT_EN
            poll_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            gap_q       <= gap_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            m_enable_q  <= m_enable_d;
            m_command_q <= m_command_d;
            m_addr_q    <= m_addr_d;
            m_data_q    <= m_data_d;
            m_rw_q      <= m_rw_d;
`ifdef QSPI_SEQ_POLL_TIMEOUT_EN
            poll_q      <= poll_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        gap_d       = gap_q;
        // Response fields are only meaningful for the single RESP cycle.
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        m_enable_d  = 1'b0;
        // Transaction fields hold until the next issue.
        m_command_d = m_command_q;
        m_addr_d    = m_addr_q;
        m_data_d    = m_data_q;
        m_rw_d      = m_rw_q;
`ifdef QSPI_SEQ_POLL_TIMEOUT_EN
        poll_d      = poll_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    op_d   = op_e'(i_req_op);
                    addr_d = i_req_addr;
                    data_d = i_req_data;
`ifdef QSPI_SEQ_POLL_TIMEOUT_EN
                    poll_d = '0;
`endif
                    case (op_e'(i_req_op))
                        OP_READ:    state_d = ST_OP_ISS;
                        OP_PROGRAM,
                        OP_ERASE:   state_d = ST_WREN_ISS;
                        default: begin
                            state_d     = ST_RESP;
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b1;
                        end
                    endcase
                end
            end

            ST_WREN_ISS: begin
                if (!i_m_busy) begin
                    m_enable_d  = 1'b1;
                    m_command_d = CMD_WREN;
                    m_addr_d    = '0;
                    m_data_d    = '0;
                    m_rw_d      = 1'b0;
                    state_d     = ST_WREN_WAIT;
                end
            end

            ST_WREN_WAIT: begin
                if (i_m_done) state_d = ST_OP_ISS;
            end

            ST_OP_ISS: begin
                if (!i_m_busy) begin
                    m_enable_d = 1'b1;
                    m_addr_d   = addr_q;
                    case (op_q)
                        OP_READ: begin
                            m_command_d = CMD_READ;
                            m_data_d    = '0;
                            m_rw_d      = 1'b1;
                        end
                        OP_PROGRAM: begin
                            m_command_d = CMD_PP;
                            m_data_d    = data_q;
                            m_rw_d      = 1'b0;
                        end
                        default: begin
                            m_command_d = CMD_SE;
                            m_data_d    = '0;
                            m_rw_d      = 1'b0;
                        end
                    endcase
                    state_d = ST_OP_WAIT;
                end
            end

            ST_OP_WAIT: begin
                if (i_m_done) begin
                    if (op_q == OP_READ) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = i_m_read_word;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = '0;
                    end
                end
            end

            // Counter saturates at POLL_GAP; with POLL_GAP=0 the first
            // GAP cycle already satisfies the compare.
            ST_GAP: begin
                if (gap_q == GAP_W'(POLL_GAP)) state_d = ST_POLL_ISS;
                else                           gap_d   = gap_q + GAP_W'(1);
            end

            ST_POLL_ISS: begin
                if (!i_m_busy) begin
                    m_enable_d  = 1'b1;
                    m_command_d = CMD_RDSR;
                    m_addr_d    = '0;
                    m_data_d    = '0;
                    m_rw_d      = 1'b1;
`ifdef QSPI_SEQ_POLL_TIMEOUT_EN
                    poll_d      = poll_q + POLL_W'(1);
`endif
                    state_d     = ST_POLL_WAIT;
                end
            end

            ST_POLL_WAIT: begin
                if (i_m_done) begin
                    if (i_m_read_word[0]) begin
`ifdef QSPI_SEQ_POLL_TIMEOUT_EN
                        if (poll_q >= POLL_W'(POLL_MAX)) begin
                            state_d     = ST_RESP;
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                            gap_d   = '0;
                        end
`else
                        state_d = ST_GAP;
                        gap_d   = '0;
`endif
                    end else begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                    end
                end
            end

            ST_RESP: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    assign o_req_ready      = (state_q == ST_IDLE);
    assign o_rsp_valid      = rsp_valid_q;
    assign o_rsp_data       = rsp_data_q;
    assign o_rsp_err        = rsp_err_q;
    assign o_m_enable       = m_enable_q;
    assign o_m_command      = m_command_q;
    assign o_m_addr         = m_addr_q;
    assign o_m_data         = m_data_q;
    assign o_m_rw           = m_rw_q;
    assign o_m_burst_enable = 1'b0;

endmodule

// File: tb/tb_qspi_flash_seq.sv
// -----------------------------------------------------------------------------
// tb_qspi_flash_seq
// Scoreboard bench for qspi_flash_seq: directed requests push expected master
// transactions and responses into queues; a monitor pops and compares them
// whenever the DUT pulses o_m_enable or o_rsp_valid. A small master model
// answers each transaction after a few busy cycles.
// -----------------------------------------------------------------------------
module tb_qspi_flash_seq;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 24;
    localparam int POLL_GAP = 4;
    localparam int POLL_MAX = 4;

    typedef struct {
        logic [7:0]        cmd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              rw;
        bit                ca;   // compare address
        bit                cd;   // compare data
    } txn_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              err;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_op = 2'b00;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_data = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              m_enable;
    logic [7:0]        m_command;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic              m_rw;
    logic              m_burst;
    logic              m_busy_model = 1'b0;
    logic              busy_force = 1'b0;
    logic              m_busy;
    logic              m_done = 1'b0;
    logic [DATA_W-1:0] m_rd = '0;

    assign m_busy = m_busy_model | busy_force;

    qspi_flash_seq #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_op(req_op), .i_req_addr(req_addr), .i_req_data(req_data),
        .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
        .o_m_enable(m_enable), .o_m_command(m_command), .o_m_addr(m_addr),
        .o_m_data(m_data), .o_m_rw(m_rw), .o_m_burst_enable(m_burst),
        .i_m_busy(m_busy), .i_m_done(m_done), .i_m_read_word(m_rd)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   en_count = 0;
    int   rsp_count = 0;
    int   last_done_cyc = -1000;
    int   last_rsp_cyc = 0;
    int   acc_cyc = 0;
    txn_t exp_txn_q[$];
    rsp_t exp_rsp_q[$];
    logic [DATA_W-1:0] rd_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Master model: busy for 3 cycles after each start pulse, then a done
    // pulse carrying the next queued read word for read transactions.
    int          mcnt = 0;
    logic        cur_rw = 1'b0;
    logic [7:0]  cur_cmd = '0;
    logic [ADDR_W-1:0] cur_addr = '0;
    logic [DATA_W-1:0] cur_data = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy_model = 1'b0;
            m_done       = 1'b0;
            mcnt         = 0;
        end else begin
            m_done = 1'b0;
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    chk("hold_cmd",  {56'd0, m_command}, {56'd0, cur_cmd});
                    chk("hold_addr", {40'd0, m_addr},    {40'd0, cur_addr});
                    chk("hold_data", {32'd0, m_data},    {32'd0, cur_data});
                    m_busy_model  = 1'b0;
                    m_done        = 1'b1;
                    last_done_cyc = cyc;
                    m_rd = (cur_rw && rd_q.size() > 0) ? rd_q.pop_front() : '0;
                end
            end else if (m_enable) begin
                m_busy_model = 1'b1;
                mcnt     = 3;
                cur_rw   = m_rw;
                cur_cmd  = m_command;
                cur_addr = m_addr;
                cur_data = m_data;
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            chk("burst_tied0", {63'd0, m_burst}, 64'd0);
            if (m_enable) begin
                en_count++;
                if (exp_txn_q.size() == 0) begin
                    chk("unexpected_txn_cmd", {56'd0, m_command}, 64'd0);
                end else begin
                    txn_t e;
                    e = exp_txn_q.pop_front();
                    chk("txn_cmd", {56'd0, m_command}, {56'd0, e.cmd});
                    chk("txn_rw",  {63'd0, m_rw},      {63'd0, e.rw});
                    if (e.ca) chk("txn_addr", {40'd0, m_addr}, {40'd0, e.addr});
                    if (e.cd) chk("txn_data", {32'd0, m_data}, {32'd0, e.data});
                    if (m_command == 8'h05)
                        chk("poll_gap_ok", {63'd0, ((cyc - last_done_cyc - 1) >= POLL_GAP)}, 64'd1);
                end
            end
            if (rsp_valid) begin
                rsp_count++;
                last_rsp_cyc = cyc;
                if (exp_rsp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    rsp_t r;
                    r = exp_rsp_q.pop_front();
                    chk("rsp_data", {32'd0, rsp_data}, {32'd0, r.data});
                    chk("rsp_err",  {63'd0, rsp_err},  {63'd0, r.err});
                end
            end
        end
    end

    function automatic txn_t mk(input logic [7:0] c, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d, input logic rw,
                                input bit ca, input bit cd);
        txn_t t;
        t.cmd = c; t.addr = a; t.data = d; t.rw = rw; t.ca = ca; t.cd = cd;
        return t;
    endfunction

    function automatic rsp_t mr(input logic [DATA_W-1:0] d, input logic e);
        rsp_t r;
        r.data = d; r.err = e;
        return r;
    endfunction

    task automatic send(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
        int n;
        n = 0;
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", 64'd0, 64'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_data  = d;
        acc_cyc   = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_addr  = '0;
        req_data  = '0;
    endtask

    task automatic wait_rsp(input int start);
        int n;
        n = 0;
        while (rsp_count == start && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (rsp_count == start) chk("rsp_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int s, e0;
        repeat (3) @(negedge clk);
        chk("rst_ready",     {63'd0, req_ready}, 64'd1);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_m_enable",  {63'd0, m_enable},  64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("init_ready",    {63'd0, req_ready}, 64'd1);
        chk("init_rsp_err",  {63'd0, rsp_err},   64'd0);
        chk("init_rsp_data", {32'd0, rsp_data},  64'd0);
        chk("init_cmd",      {56'd0, m_command}, 64'd0);
        chk("init_addr",     {40'd0, m_addr},    64'd0);
        chk("init_data",     {32'd0, m_data},    64'd0);
        chk("init_rw",       {63'd0, m_rw},      64'd0);

        // READ
        exp_txn_q.push_back(mk(8'h03, 24'h000100, '0, 1'b1, 1, 0));
        exp_rsp_q.push_back(mr(32'hA5A5_5A5A, 1'b0));
        rd_q.push_back(32'hA5A5_5A5A);
        s = rsp_count;
        send(2'b00, 24'h000100, '0);
        wait_rsp(s);

        // PROGRAM: WIP 1,1,0
        exp_txn_q.push_back(mk(8'h06, '0, '0, 1'b0, 0, 0));
        exp_txn_q.push_back(mk(8'h02, 24'h000200, 32'h1234_5678, 1'b0, 1, 1));
        repeat (3) exp_txn_q.push_back(mk(8'h05, '0, '0, 1'b1, 0, 0));
        rd_q.push_back(32'h1); rd_q.push_back(32'h1); rd_q.push_back(32'h0);
        exp_rsp_q.push_back(mr('0, 1'b0));
        s = rsp_count;
        send(2'b01, 24'h000200, 32'h1234_5678);
        wait_rsp(s);

        // ERASE: WIP 1,0; data field of SE must be 0
        exp_txn_q.push_back(mk(8'h06, '0, '0, 1'b0, 0, 0));
        exp_txn_q.push_back(mk(8'hD8, 24'h010000, '0, 1'b0, 1, 1));
        repeat (2) exp_txn_q.push_back(mk(8'h05, '0, '0, 1'b1, 0, 0));
        rd_q.push_back(32'h1); rd_q.push_back(32'h0);
        exp_rsp_q.push_back(mr('0, 1'b0));
        s = rsp_count;
        send(2'b10, 24'h010000, 32'hFFFF_FFFF);
        wait_rsp(s);

        // Reserved op
        exp_rsp_q.push_back(mr('0, 1'b1));
        s  = rsp_count;
        e0 = en_count;
        send(2'b11, 24'h000ABC, 32'h0);
        wait_rsp(s);
        chk("rsvd_latency", 64'(last_rsp_cyc - acc_cyc), 64'd1);
        chk("rsvd_no_enable", 64'(en_count - e0), 64'd0);

        // Busy held in OP_ISS for 20 cycles
        busy_force = 1'b1;
        exp_txn_q.push_back(mk(8'h03, 24'h000300, '0, 1'b1, 1, 0));
        exp_rsp_q.push_back(mr(32'hDEAD_BEEF, 1'b0));
        rd_q.push_back(32'hDEAD_BEEF);
        s  = rsp_count;
        e0 = en_count;
        send(2'b00, 24'h000300, '0);
        repeat (20) @(negedge clk);
        chk("busy_no_enable", 64'(en_count - e0), 64'd0);
        busy_force = 1'b0;
        wait_rsp(s);
        chk("busy_one_enable", 64'(en_count - e0), 64'd1);

        // Reset during POLL_WAIT
        exp_txn_q.push_back(mk(8'h06, '0, '0, 1'b0, 0, 0));
        exp_txn_q.push_back(mk(8'h02, 24'h000400, 32'h55AA_55AA, 1'b0, 1, 1));
        exp_txn_q.push_back(mk(8'h05, '0, '0, 1'b1, 0, 0));
        repeat (3) rd_q.push_back(32'h1);
        s  = rsp_count;
        e0 = en_count;
        send(2'b01, 24'h000400, 32'h55AA_55AA);
        for (int i = 0; i < 2000 && en_count < e0 + 3; i++) @(negedge clk);
        chk("rst_reached_poll", 64'(en_count - e0), 64'd3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready",     {63'd0, req_ready}, 64'd1);
        chk("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("midrst_m_enable",  {63'd0, m_enable},  64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_q.delete();
        repeat (10) @(negedge clk);
        chk("midrst_no_rsp", 64'(rsp_count - s), 64'd0);
        chk("midrst_idle",   {63'd0, req_ready}, 64'd1);

`ifdef QSPI_SEQ_POLL_TIMEOUT_EN
        // Poll timeout: WIP stuck at 1 -> exactly POLL_MAX RDSR then err
        exp_txn_q.push_back(mk(8'h06, '0, '0, 1'b0, 0, 0));
        exp_txn_q.push_back(mk(8'h02, 24'h000500, 32'h0BAD_F00D, 1'b0, 1, 1));
        repeat (POLL_MAX) exp_txn_q.push_back(mk(8'h05, '0, '0, 1'b1, 0, 0));
        repeat (POLL_MAX + 4) rd_q.push_back(32'h1);
        exp_rsp_q.push_back(mr('0, 1'b1));
        s  = rsp_count;
        e0 = en_count;
        send(2'b01, 24'h000500, 32'h0BAD_F00D);
        wait_rsp(s);
        chk("timeout_enables", 64'(en_count - e0), 64'(POLL_MAX + 2));
        rd_q.delete();
`endif

        repeat (5) @(negedge clk);
        chk("txn_queue_empty", 64'(exp_txn_q.size()), 64'd0);
        chk("rsp_queue_empty", 64'(exp_rsp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qspi_flash_seq.md
Name: qspi_flash_seq

Overview:
- Upstream command sequencer for qspi_master; turns single host requests (READ / PROGRAM / ERASE) into the flash command sequence the N25Q-class device needs.
- PROGRAM and ERASE run as WREN, then the operation, then RDSR polling until WIP=0.
- Drives qspi_master's request inputs and consumes its o_busy / o_done / o_read_word.
- Burst transfers are out of scope: o_m_burst_enable is tied 0.

Parameters:
- DATA_W, 32, data word width, equal to qspi_master i_data / o_read_word width.
- ADDR_W, 24, flash address width.
- POLL_GAP, 16, idle clocks between successive RDSR transactions (0 allowed).
- POLL_MAX, 4096, maximum RDSR transactions before timeout (used only with the optional feature).

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  1  host request valid.
- o_req_ready  out  1  high only in IDLE.
- i_req_op  in  2  operation: 00 READ, 01 PROGRAM, 10 ERASE, 11 reserved.
- i_req_addr  in  ADDR_W  flash address.
- i_req_data  in  DATA_W  program data.
- o_rsp_valid  out  1  one-cycle completion pulse.
- o_rsp_data  out  DATA_W  read data; 0 for PROGRAM and ERASE.
- o_rsp_err  out  1  qualified by o_rsp_valid: reserved op or poll timeout.
- o_m_enable  out  1  one-cycle start pulse to the master.
- o_m_command  out  8  flash opcode.
- o_m_addr  out  ADDR_W  master address.
- o_m_data  out  DATA_W  master write data.
- o_m_rw  out  1  1 = read transaction, 0 = write transaction.
- o_m_burst_enable  out  1  constant 0.
- i_m_busy  in  1  master busy.
- i_m_done  in  1  master one-cycle done pulse.
- i_m_read_word  in  DATA_W  master read result.

Behaviour:
- Reset: asynchronous, active-low; state returns to IDLE. Outputs at reset:
  - o_req_ready=1.
  - o_rsp_valid=0, o_rsp_err=0, o_rsp_data=0.
  - o_m_enable=0, o_m_command=0, o_m_addr=0, o_m_data=0, o_m_rw=0.
- Reset mid-operation aborts the sequence with no response. The master shares the same reset.
- Accept: when i_req_valid && o_req_ready, op/addr/data are latched and o_req_ready drops on the next cycle. Inputs are ignored outside IDLE.
- Opcodes: WREN 0x06, READ 0x03 (rw=1), PP 0x02 (rw=0), SE 0xD8 (rw=0), RDSR 0x05 (rw=1).
- States: IDLE, WREN_ISS, WREN_WAIT, OP_ISS, OP_WAIT, GAP, POLL_ISS, POLL_WAIT, RESP.
- Issue rule for every *_ISS state:
  - The state waits while i_m_busy=1.
  - Once i_m_busy=0, it drives command/addr/data/rw and pulses o_m_enable for exactly one cycle, then moves to the matching *_WAIT state.
  - The command/addr/data/rw fields stay stable until the matching i_m_done.
- i_m_done is sampled only in *_WAIT states; any i_m_done seen elsewhere is ignored.
- Flow per op:
  - READ: IDLE → OP_ISS → OP_WAIT → RESP. o_rsp_data = i_m_read_word captured on i_m_done.
  - PROGRAM / ERASE: IDLE → WREN_ISS → WREN_WAIT → OP_ISS → OP_WAIT → GAP → POLL_ISS → POLL_WAIT.
    - In POLL_WAIT on i_m_done: if i_m_read_word[0]=1 (WIP), go to GAP; otherwise go to RESP.
    - GAP counts POLL_GAP cycles; POLL_GAP=0 passes straight to POLL_ISS in one cycle.
    - ERASE sends no data (o_m_data=0).
- Reserved op 11: IDLE → RESP with o_rsp_err=1 and no master transaction.
- RESP: o_rsp_valid=1 for one cycle, then IDLE (o_req_ready=1 on the following cycle). Minimum READ latency = accept + 1 + master time + 1.
- Counters: the gap counter is $clog2(POLL_GAP+1) bits wide and saturates; the poll counter is $clog2(POLL_MAX+1) bits wide.

Optional Feature:
- Macro QSPI_SEQ_POLL_TIMEOUT_EN.
- Defined: each RDSR increments the poll counter. When the counter reaches POLL_MAX while WIP is still 1, the block goes to RESP with o_rsp_err=1. The counter clears on accept.
- Undefined: no counter; polling continues until WIP=0, and o_rsp_err is set only for the reserved op.

Decomposition:
- Shared package qspi_seq_pkg holds:
  - the opcode localparams (CMD_WREN, CMD_READ, CMD_PP, CMD_SE, CMD_RDSR);
  - typedef enum op_e {OP_READ, OP_PROGRAM, OP_ERASE, OP_RSVD} (2 bits);
  - typedef enum state_e for the FSM.
- No sub-module; the FSM and both counters stay in one module.

Test Plan:
- READ addr 0x000100, master returns 0xA5A5_5A5A → one transaction, command 0x03, rw=1, o_rsp_data=0xA5A5_5A5A, o_rsp_err=0.
- PROGRAM addr 0x000200 data 0x1234_5678, status reads 0x01,0x01,0x00 → sequence 0x06, 0x02, then 3×0x05 each separated by ≥POLL_GAP idle cycles; one rsp, err=0.
- ERASE addr 0x010000 → 0x06, then 0xD8 with o_m_data=0, polls until WIP=0; rsp_data=0.
- i_req_op=11 → rsp_valid one cycle after accept, err=1, o_m_enable never asserted.
- i_m_busy held 1 for 20 cycles in OP_ISS → o_m_enable stays 0 until busy drops, then exactly one pulse; i_rst_n low during POLL_WAIT → immediate IDLE, o_req_ready=1, no rsp.
- With QSPI_SEQ_POLL_TIMEOUT_EN and POLL_MAX=4, status constantly 0x01 → exactly 4 RDSR, then rsp err=1.
